// File: rtl/tron_pkg.sv
// Shared definitions for the TRON position tracker: heading codes, FSM
// state encoding and the heading-reversal helper.
package tron_pkg;

    localparam logic [1:0] DIR_DOWN  = 2'b00;  // y+1
    localparam logic [1:0] DIR_RIGHT = 2'b01;  // x+1
    localparam logic [1:0] DIR_UP    = 2'b10;  // y-1
    localparam logic [1:0] DIR_LEFT  = 2'b11;  // x-1

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_RUN     = 2'b01,
        ST_CRASHED = 2'b10
    } tron_state_e;

    // Flipping bit 1 of a heading yields its opposite direction.
    function automatic logic is_reverse(input logic [1:0] req, input logic [1:0] cur);
        return req == (cur ^ 2'b10);
    endfunction

endpackage

// File: rtl/tron_position_tracker_if.sv
// Control/status bundle between the game controller and the position tracker.
interface tron_position_tracker_if #(
    parameter int N_PLAYERS = 2,
    parameter int X_WIDTH   = 8,
    parameter int Y_WIDTH   = 7
);
    logic                           start;
    logic                           step;
    logic [2*N_PLAYERS-1:0]         dir_in;
    logic [N_PLAYERS-1:0]           dir_valid;
    logic [X_WIDTH*N_PLAYERS-1:0]   x;
    logic [Y_WIDTH*N_PLAYERS-1:0]   y;
    logic [2*N_PLAYERS-1:0]         dir;
    logic [N_PLAYERS-1:0]           alive;
    logic                           moved;
    logic                           game_over;

    modport master (output start, step, dir_in, dir_valid,
                    input  x, y, dir, alive, moved, game_over);
    modport slave  (input  start, step, dir_in, dir_valid,
                    output x, y, dir, alive, moved, game_over);
endinterface

// File: rtl/tron_player_pos.sv
// One light-cycle: head position, heading, pending heading and alive bit.
// Arena edges are fatal unless TRON_WRAP_EN is defined (toroidal arena).
module tron_player_pos
    import tron_pkg::*;
#(
    parameter int               X_WIDTH = 8,
    parameter int               Y_WIDTH = 7,
    parameter logic [X_WIDTH-1:0] X_MAX  = 8'd159,
    parameter logic [Y_WIDTH-1:0] Y_MAX  = 7'd119,
    parameter logic [X_WIDTH-1:0] X_INIT = 8'd40,
    parameter logic [Y_WIDTH-1:0] Y_INIT = 7'd60,
    parameter logic [1:0]         D_INIT = 2'b01
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_run,
    input  logic               i_reload,
    input  logic               i_step,
    input  logic [1:0]         i_dir_in,
    input  logic               i_dir_valid,
    output logic [X_WIDTH-1:0] o_x,
    output logic [Y_WIDTH-1:0] o_y,
    output logic [1:0]         o_dir,
    output logic               o_alive,
    output logic               o_alive_nxt
);

    logic [X_WIDTH-1:0] r_x;
    logic [Y_WIDTH-1:0] r_y;
    logic [1:0]         r_dir;
    logic [1:0]         r_pend;
    logic               r_alive;

    logic               w_req_ok;
    logic               w_move;
    logic [1:0]         w_head;
    logic [X_WIDTH-1:0] w_x_nxt;
    logic [Y_WIDTH-1:0] w_y_nxt;
    logic               w_oob;

`ifdef TRON_WRAP_EN
    localparam logic [X_WIDTH-1:0] X_ONE = {{(X_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [Y_WIDTH-1:0] Y_ONE = {{(Y_WIDTH-1){1'b0}}, 1'b1};
`else
    localparam logic [X_WIDTH:0] X_ONE = {{X_WIDTH{1'b0}}, 1'b1};
    localparam logic [Y_WIDTH:0] Y_ONE = {{Y_WIDTH{1'b0}}, 1'b1};
    logic [X_WIDTH:0] w_x_ext;
    logic [Y_WIDTH:0] w_y_ext;
`endif

    // Request acceptance and the heading that a step in this cycle would use.
    always_comb begin
        w_req_ok = i_run & i_dir_valid & ~is_reverse(i_dir_in, r_dir);
        w_move   = i_run & i_step & r_alive;
        if (w_req_ok) begin
            w_head = i_dir_in;
        end else begin
            w_head = r_pend;
        end
    end

`ifdef TRON_WRAP_EN
    // Toroidal move: each edge wraps to the opposite one.
    always_comb begin
        w_x_nxt = r_x;
        w_y_nxt = r_y;
        w_oob   = 1'b0;
        case (w_head)
            DIR_DOWN:  w_y_nxt = (r_y == Y_MAX) ? {Y_WIDTH{1'b0}} : r_y + Y_ONE;
            DIR_RIGHT: w_x_nxt = (r_x == X_MAX) ? {X_WIDTH{1'b0}} : r_x + X_ONE;
            DIR_UP:    w_y_nxt = (r_y == {Y_WIDTH{1'b0}}) ? Y_MAX : r_y - Y_ONE;
            DIR_LEFT:  w_x_nxt = (r_x == {X_WIDTH{1'b0}}) ? X_MAX : r_x - X_ONE;
            default:   w_oob   = 1'b0;
        endcase
    end
`else
    // One extra bit lets underflow at 0 show up as a value above the max.
    always_comb begin
        w_x_ext = {1'b0, r_x};
        w_y_ext = {1'b0, r_y};
        case (w_head)
            DIR_DOWN:  w_y_ext = {1'b0, r_y} + Y_ONE;
            DIR_RIGHT: w_x_ext = {1'b0, r_x} + X_ONE;
            DIR_UP:    w_y_ext = {1'b0, r_y} - Y_ONE;
            DIR_LEFT:  w_x_ext = {1'b0, r_x} - X_ONE;
            default:   w_x_ext = {1'b0, r_x};
        endcase
        w_oob   = (w_x_ext > {1'b0, X_MAX}) | (w_y_ext > {1'b0, Y_MAX});
        w_x_nxt = w_x_ext[X_WIDTH-1:0];
        w_y_nxt = w_y_ext[Y_WIDTH-1:0];
    end
`endif

    // Position, heading, pending heading and alive state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x     <= X_INIT;
            r_y     <= Y_INIT;
            r_dir   <= D_INIT;
            r_pend  <= D_INIT;
            r_alive <= 1'b1;
        end else if (i_reload) begin
            r_x     <= X_INIT;
            r_y     <= Y_INIT;
            r_dir   <= D_INIT;
            r_pend  <= D_INIT;
            r_alive <= 1'b1;
        end else if (w_move) begin
            r_dir  <= w_head;
            r_pend <= w_head;
            if (w_oob) begin
                r_alive <= 1'b0;
            end else begin
                r_x <= w_x_nxt;
                r_y <= w_y_nxt;
            end
        end else if (w_req_ok) begin
            r_pend <= i_dir_in;
        end
    end

    assign o_x         = r_x;
    assign o_y         = r_y;
    assign o_dir       = r_dir;
    assign o_alive     = r_alive;
    assign o_alive_nxt = w_move ? ~w_oob : r_alive;

endmodule

// File: rtl/tron_position_tracker.sv
// TRON multi-player coordinate engine: IDLE/RUN/CRASHED FSM, live count and
// move pulse around N_PLAYERS tron_player_pos instances. Option: TRON_WRAP_EN.
module tron_position_tracker
    import tron_pkg::*;
#(
    parameter int N_PLAYERS = 2,
    parameter int X_WIDTH   = 8,
    parameter int Y_WIDTH   = 7,
    parameter logic [X_WIDTH-1:0]           X_MAX  = 8'd159,
    parameter logic [Y_WIDTH-1:0]           Y_MAX  = 7'd119,
    parameter logic [X_WIDTH*N_PLAYERS-1:0] X_INIT = {8'd120, 8'd40},
    parameter logic [Y_WIDTH*N_PLAYERS-1:0] Y_INIT = {7'd60, 7'd60},
    parameter logic [2*N_PLAYERS-1:0]       D_INIT = {2'b11, 2'b01}
) (
    input  logic                    CLOCK_50,
    input  logic                    resetn,
    tron_position_tracker_if.slave  bus
);

    // A lone player crashes only when it dies; otherwise one survivor ends it.
    localparam logic [2:0] LIVE_MIN = (N_PLAYERS == 1) ? 3'd0 : 3'd1;

    tron_state_e            r_state;
    tron_state_e            w_state_nxt;
    logic                   w_run;
    logic                   w_reload;
    logic                   w_step_run;
    logic [N_PLAYERS-1:0]   w_alive_nxt;
    logic [2:0]             w_live_cnt;
    logic                   r_moved;
    logic                   r_game_over;

    genvar gi;
    generate
        for (gi = 0; gi < N_PLAYERS; gi++) begin : g_player
            tron_player_pos #(
                .X_WIDTH (X_WIDTH),
                .Y_WIDTH (Y_WIDTH),
                .X_MAX   (X_MAX),
                .Y_MAX   (Y_MAX),
                .X_INIT  (X_INIT[gi*X_WIDTH +: X_WIDTH]),
                .Y_INIT  (Y_INIT[gi*Y_WIDTH +: Y_WIDTH]),
                .D_INIT  (D_INIT[gi*2 +: 2])
            ) u_player (
                .clk         (CLOCK_50),
                .rst_n       (resetn),
                .i_run       (w_run),
                .i_reload    (w_reload),
                .i_step      (bus.step),
                .i_dir_in    (bus.dir_in[gi*2 +: 2]),
                .i_dir_valid (bus.dir_valid[gi]),
                .o_x         (bus.x[gi*X_WIDTH +: X_WIDTH]),
                .o_y         (bus.y[gi*Y_WIDTH +: Y_WIDTH]),
                .o_dir       (bus.dir[gi*2 +: 2]),
                .o_alive     (bus.alive[gi]),
                .o_alive_nxt (w_alive_nxt[gi])
            );
        end
    endgenerate

    // Number of players still alive once this cycle's move is applied.
    always_comb begin
        w_live_cnt = 3'd0;
        for (int i = 0; i < N_PLAYERS; i++) begin
            w_live_cnt = w_live_cnt + {2'b00, w_alive_nxt[i]};
        end
    end

    // FSM state register.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic; start is ignored while running.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:    w_state_nxt = bus.start ? ST_RUN : ST_IDLE;
            ST_RUN:     w_state_nxt = (w_step_run && (w_live_cnt <= LIVE_MIN)) ? ST_CRASHED : ST_RUN;
            ST_CRASHED: w_state_nxt = bus.start ? ST_RUN : ST_CRASHED;
            default:    w_state_nxt = ST_IDLE;
        endcase
    end

    // FSM decoded controls for the player datapath.
    always_comb begin
        w_run      = (r_state == ST_RUN);
        w_reload   = (r_state == ST_CRASHED) & bus.start;
        w_step_run = w_run & bus.step;
    end

    // Registered status outputs, aligned with the position update edge.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_moved     <= 1'b0;
            r_game_over <= 1'b0;
        end else begin
            r_moved     <= w_step_run;
            r_game_over <= (w_state_nxt == ST_CRASHED);
        end
    end

    assign bus.moved     = r_moved;
    assign bus.game_over = r_game_over;

endmodule

// File: tb/tb_tron_position_tracker.sv
// Directed bench for tron_position_tracker: vector table plus crash, wrap,
// restart and asynchronous reset sequences.
module tb_tron_position_tracker;

    logic CLOCK_50 = 1'b0;
    logic resetn;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 CLOCK_50 = ~CLOCK_50;

    tron_position_tracker_if #(.N_PLAYERS(2), .X_WIDTH(8), .Y_WIDTH(7)) bus ();

    tron_position_tracker dut (
        .CLOCK_50 (CLOCK_50),
        .resetn   (resetn),
        .bus      (bus)
    );

    typedef struct {
        logic        st;
        logic        sp;
        logic [1:0]  dv;
        logic [3:0]  di;
        logic [15:0] ex;
        logic [13:0] ey;
        logic [3:0]  ed;
        logic [1:0]  ea;
        logic        em;
        logic        eg;
    } vec_t;

    vec_t vt [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic drive(input logic st, input logic sp, input logic [1:0] dv, input logic [3:0] di);
        bus.start     = st;
        bus.step      = sp;
        bus.dir_valid = dv;
        bus.dir_in    = di;
    endtask

    task automatic chk_all(input string tag, input logic [15:0] ex, input logic [13:0] ey,
                           input logic [3:0] ed, input logic [1:0] ea, input logic em, input logic eg);
        chk({tag, ".x"},         {16'd0, bus.x},     {16'd0, ex});
        chk({tag, ".y"},         {18'd0, bus.y},     {18'd0, ey});
        chk({tag, ".dir"},       {28'd0, bus.dir},   {28'd0, ed});
        chk({tag, ".alive"},     {30'd0, bus.alive}, {30'd0, ea});
        chk({tag, ".moved"},     {31'd0, bus.moved}, {31'd0, em});
        chk({tag, ".game_over"}, {31'd0, bus.game_over}, {31'd0, eg});
    endtask

    initial begin
        //        st    sp    dv     di       x (P1,P0)        y (P1,P0)      dir      alive  mv    go
        vt[0]  = '{1'b0, 1'b0, 2'b00, 4'b0000, {8'd120, 8'd40}, {7'd60, 7'd60}, 4'b1101, 2'b11, 1'b0, 1'b0};
        vt[1]  = '{1'b0, 1'b1, 2'b00, 4'b0000, {8'd120, 8'd40}, {7'd60, 7'd60}, 4'b1101, 2'b11, 1'b0, 1'b0};
        vt[2]  = '{1'b1, 1'b1, 2'b00, 4'b0000, {8'd120, 8'd40}, {7'd60, 7'd60}, 4'b1101, 2'b11, 1'b0, 1'b0};
        vt[3]  = '{1'b0, 1'b1, 2'b00, 4'b0000, {8'd119, 8'd41}, {7'd60, 7'd60}, 4'b1101, 2'b11, 1'b1, 1'b0};
        vt[4]  = '{1'b0, 1'b0, 2'b00, 4'b0000, {8'd119, 8'd41}, {7'd60, 7'd60}, 4'b1101, 2'b11, 1'b0, 1'b0};
        vt[5]  = '{1'b0, 1'b0, 2'b01, 4'b0011, {8'd119, 8'd41}, {7'd60, 7'd60}, 4'b1101, 2'b11, 1'b0, 1'b0};
        vt[6]  = '{1'b0, 1'b1, 2'b00, 4'b0000, {8'd118, 8'd42}, {7'd60, 7'd60}, 4'b1101, 2'b11, 1'b1, 1'b0};
        vt[7]  = '{1'b0, 1'b1, 2'b01, 4'b0000, {8'd117, 8'd42}, {7'd60, 7'd61}, 4'b1100, 2'b11, 1'b1, 1'b0};
        vt[8]  = '{1'b1, 1'b0, 2'b00, 4'b0000, {8'd117, 8'd42}, {7'd60, 7'd61}, 4'b1100, 2'b11, 1'b0, 1'b0};
        vt[9]  = '{1'b0, 1'b0, 2'b10, 4'b1000, {8'd117, 8'd42}, {7'd60, 7'd61}, 4'b1100, 2'b11, 1'b0, 1'b0};
        vt[10] = '{1'b0, 1'b0, 2'b10, 4'b0000, {8'd117, 8'd42}, {7'd60, 7'd61}, 4'b1100, 2'b11, 1'b0, 1'b0};
        vt[11] = '{1'b0, 1'b1, 2'b01, 4'b0010, {8'd117, 8'd42}, {7'd61, 7'd62}, 4'b0000, 2'b11, 1'b1, 1'b0};
        vt[12] = '{1'b0, 1'b1, 2'b11, 4'b1101, {8'd116, 8'd43}, {7'd61, 7'd62}, 4'b1101, 2'b11, 1'b1, 1'b0};

        drive(1'b0, 1'b0, 2'b00, 4'b0000);
        resetn = 1'b0;
        repeat (3) cyc();
        resetn = 1'b1;

        for (int i = 0; i < 13; i++) begin
            drive(vt[i].st, vt[i].sp, vt[i].dv, vt[i].di);
            cyc();
            drive(1'b0, 1'b0, 2'b00, 4'b0000);
            chk_all($sformatf("vec%0d", i), vt[i].ex, vt[i].ey, vt[i].ed, vt[i].ea, vt[i].em, vt[i].eg);
        end

        // P0 runs right to the edge while P1 staircases down-left out of harm's way.
        for (int k = 0; k < 116; k++) begin
            drive(1'b0, 1'b1, 2'b10, (k % 2 == 1) ? 4'b1100 : 4'b0000);
            cyc();
        end
        drive(1'b0, 1'b0, 2'b00, 4'b0000);
        chk_all("edge_reach", {8'd58, 8'd159}, {7'd119, 7'd62}, 4'b1101, 2'b11, 1'b1, 1'b0);

`ifdef TRON_WRAP_EN
        drive(1'b0, 1'b1, 2'b00, 4'b0000);
        cyc();
        drive(1'b0, 1'b0, 2'b00, 4'b0000);
        chk_all("wrap_step", {8'd57, 8'd0}, {7'd119, 7'd62}, 4'b1101, 2'b11, 1'b1, 1'b0);
`else
        drive(1'b0, 1'b1, 2'b00, 4'b0000);
        cyc();
        drive(1'b0, 1'b0, 2'b00, 4'b0000);
        chk_all("crash_step", {8'd57, 8'd159}, {7'd119, 7'd62}, 4'b1101, 2'b10, 1'b1, 1'b1);

        drive(1'b0, 1'b1, 2'b00, 4'b0000);
        cyc();
        drive(1'b0, 1'b0, 2'b00, 4'b0000);
        chk_all("crashed_step", {8'd57, 8'd159}, {7'd119, 7'd62}, 4'b1101, 2'b10, 1'b0, 1'b1);

        drive(1'b1, 1'b1, 2'b00, 4'b0000);
        cyc();
        drive(1'b0, 1'b0, 2'b00, 4'b0000);
        chk_all("restart", {8'd120, 8'd40}, {7'd60, 7'd60}, 4'b1101, 2'b11, 1'b0, 1'b0);
`endif

        drive(1'b0, 1'b1, 2'b00, 4'b0000);
        cyc();
        drive(1'b0, 1'b0, 2'b00, 4'b0000);
`ifdef TRON_WRAP_EN
        chk_all("run_step", {8'd56, 8'd1}, {7'd119, 7'd62}, 4'b1101, 2'b11, 1'b1, 1'b0);
`else
        chk_all("run_step", {8'd119, 8'd41}, {7'd60, 7'd60}, 4'b1101, 2'b11, 1'b1, 1'b0);
`endif

        // Reset asserted between clock edges must take effect without a clock.
        #2;
        resetn = 1'b0;
        #1;
        chk_all("async_reset", {8'd120, 8'd40}, {7'd60, 7'd60}, 4'b1101, 2'b11, 1'b0, 1'b0);
        cyc();
        resetn = 1'b1;

        drive(1'b0, 1'b1, 2'b00, 4'b0000);
        cyc();
        drive(1'b0, 1'b0, 2'b00, 4'b0000);
        chk_all("idle_step", {8'd120, 8'd40}, {7'd60, 7'd60}, 4'b1101, 2'b11, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
